// File: rtl/hdr_pkg.sv
// Shared types and defaults for the HDR exposure-stream aligner.
package hdr_pkg;

  localparam int unsigned HDR_DATA_W_DEF     = 32;
  localparam int unsigned HDR_FIFO_DEPTH_DEF = 16;
  localparam int unsigned HDR_CNT_W_DEF      = 16;

  typedef enum logic {ST_SYNC, ST_RUN} align_state_t;

  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [HDR_DATA_W_DEF-1:0] data;
  } hdr_beat_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head word is valid on rdata whenever !empty.
module sync_fifo_fwft #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic          push, pop;

  assign push = wr && !full_q;
  assign pop  = rd && (count_q != '0);

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Full is registered from the next occupancy so ready upstream is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;

endmodule

// File: rtl/hdr_stream_aligner.sv
// Buffers short/long exposure streams and emits them as one pixel-locked paired stream,
// dropping beats until both heads sit on start-of-frame and resyncing on sop/eop disagreement.
module hdr_stream_aligner
  import hdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HDR_DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = HDR_FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = HDR_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  asi_snk_0_valid_i,
  output logic                  asi_snk_0_ready_o,
  input  logic [DATA_WIDTH-1:0] asi_snk_0_data_i,
  input  logic                  asi_snk_0_startofpacket_i,
  input  logic                  asi_snk_0_endofpacket_i,
  input  logic                  asi_snk_1_valid_i,
  output logic                  asi_snk_1_ready_o,
  input  logic [DATA_WIDTH-1:0] asi_snk_1_data_i,
  input  logic                  asi_snk_1_startofpacket_i,
  input  logic                  asi_snk_1_endofpacket_i,
  output logic                  aso_src_valid_o,
  input  logic                  aso_src_ready_i,
  output logic [DATA_WIDTH-1:0] aso_src_data_0_o,
  output logic [DATA_WIDTH-1:0] aso_src_data_1_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic                  sync_err_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic [CNT_W-1:0]      frame_cnt_o
);

  localparam int unsigned BEAT_W = DATA_WIDTH + 2;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t        wbeat0, wbeat1, head0, head1;
  logic         empty0, empty1, full0, full1;
  logic         wr0, wr1, pop0, pop1;
  logic         drop0, drop1, frame_inc, valid_c, err_c;
  align_state_t state_q, state_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, frame_cnt_q;
  logic [SUM_W-1:0] drop_sum;

  assign asi_snk_0_ready_o = !full0 && !rst;
  assign asi_snk_1_ready_o = !full1 && !rst;
  assign wr0 = asi_snk_0_valid_i && asi_snk_0_ready_o;
  assign wr1 = asi_snk_1_valid_i && asi_snk_1_ready_o;
  assign wbeat0 = {asi_snk_0_startofpacket_i, asi_snk_0_endofpacket_i, asi_snk_0_data_i};
  assign wbeat1 = {asi_snk_1_startofpacket_i, asi_snk_1_endofpacket_i, asi_snk_1_data_i};

  sync_fifo_fwft #(.W(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk(clk), .rst(rst), .wr(wr0), .wdata(wbeat0),
    .rd(pop0), .rdata(head0), .empty(empty0), .full(full0)
  );

  sync_fifo_fwft #(.W(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk(clk), .rst(rst), .wr(wr1), .wdata(wbeat1),
    .rd(pop1), .rdata(head1), .empty(empty1), .full(full1)
  );

  // Next-state and pop control; a channel already at sop is held while the other catches up.
  always_comb begin
    state_d   = state_q;
    pop0      = 1'b0;
    pop1      = 1'b0;
    drop0     = 1'b0;
    drop1     = 1'b0;
    frame_inc = 1'b0;
    valid_c   = 1'b0;
    err_c     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        drop0 = !empty0 && !head0.sop;
        drop1 = !empty1 && !head1.sop;
        pop0  = drop0;
        pop1  = drop1;
        if (!empty0 && !empty1 && head0.sop && head1.sop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!empty0 && !empty1) begin
          if ((head0.sop == head1.sop) && (head0.eop == head1.eop)) begin
            valid_c = 1'b1;
            if (aso_src_ready_i) begin
              pop0      = 1'b1;
              pop1      = 1'b1;
              frame_inc = head0.eop;
            end
          end else begin
            err_c   = 1'b1;
            state_d = ST_SYNC;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
    if (rst) begin
      pop0    = 1'b0;
      pop1    = 1'b0;
      valid_c = 1'b0;
      err_c   = 1'b0;
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + SUM_W'(drop0) + SUM_W'(drop1);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_q + CNT_W'(frame_inc);
    end
  end

  assign aso_src_valid_o         = valid_c;
  assign aso_src_data_0_o        = head0.data;
  assign aso_src_data_1_o        = head1.data;
  assign aso_src_startofpacket_o = head0.sop;
  assign aso_src_endofpacket_o   = head0.eop;
  assign sync_err_o              = err_c;
  assign drop_cnt_o              = drop_cnt_q;
  assign frame_cnt_o             = frame_cnt_q;

endmodule

// File: tb/tb_hdr_stream_aligner.sv
// Directed bench for hdr_stream_aligner: per-channel beat queues drive the sinks,
// a monitor collects transferred pairs, and results are compared to hand-built expectations.
module tb_hdr_stream_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s0_valid, s0_ready, s0_sop, s0_eop;
  logic [31:0] s0_data;
  logic        s1_valid, s1_ready, s1_sop, s1_eop;
  logic [31:0] s1_data;
  logic        m_valid, src_ready, m_sop, m_eop, m_err;
  logic [31:0] m_d0, m_d1;
  logic [15:0] drop_cnt, frame_cnt;

  hdr_stream_aligner dut (
    .clk(clk), .rst(rst),
    .asi_snk_0_valid_i(s0_valid), .asi_snk_0_ready_o(s0_ready), .asi_snk_0_data_i(s0_data),
    .asi_snk_0_startofpacket_i(s0_sop), .asi_snk_0_endofpacket_i(s0_eop),
    .asi_snk_1_valid_i(s1_valid), .asi_snk_1_ready_o(s1_ready), .asi_snk_1_data_i(s1_data),
    .asi_snk_1_startofpacket_i(s1_sop), .asi_snk_1_endofpacket_i(s1_eop),
    .aso_src_valid_o(m_valid), .aso_src_ready_i(src_ready),
    .aso_src_data_0_o(m_d0), .aso_src_data_1_o(m_d1),
    .aso_src_startofpacket_o(m_sop), .aso_src_endofpacket_o(m_eop),
    .sync_err_o(m_err), .drop_cnt_o(drop_cnt), .frame_cnt_o(frame_cnt)
  );

  typedef logic [33:0] beat_t;
  typedef logic [65:0] pair_t;

  beat_t q0[$], q1[$];
  pair_t out_q[$], exp_q[$];
  int    cyc = 0;
  int    hold0, hold1, sop_cyc0, sop_cyc1, first_v, err_cnt;
  int    vec_cnt = 0;
  int    miscompares = 0;
  bit    acc0 = 1'b0;
  bit    acc1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] px(input int ch, input int fid, input int i);
    return 32'((ch << 28) | (fid << 8) | i);
  endfunction

  task automatic push_beats(input int ch, input int fid, input int n, input int sop_at, input int eop_at);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = {1'(i == sop_at), 1'(i == eop_at), px(ch, fid, i)};
      if (ch == 0) q0.push_back(b);
      else         q1.push_back(b);
    end
  endtask

  task automatic expect_pairs(input int fid, input int n, input int eop_at);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'(i == 0), 1'(i == eop_at), px(0, fid, i), px(1, fid, i)});
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_count"}, 80'(out_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk({tag, "_pair"}, 80'(out_q[i]), 80'(exp_q[i]));
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds rst for exactly one sampled edge.
  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    hold0 = 0;
    hold1 = 0;
    src_ready = 1'b1;
    #1;
    chk("rst_ready0", 80'(s0_ready), 80'(0));
    chk("rst_ready1", 80'(s1_ready), 80'(0));
    chk("rst_valid", 80'(m_valid), 80'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    exp_q.delete();
    err_cnt = 0;
    first_v = -1;
    #1;
    chk("post_rst_valid", 80'(m_valid), 80'(0));
    chk("post_rst_err", 80'(m_err), 80'(0));
    chk("post_rst_drop", 80'(drop_cnt), 80'(0));
    chk("post_rst_frame", 80'(frame_cnt), 80'(0));
    chk("post_rst_ready0", 80'(s0_ready), 80'(1));
  endtask

  // Source drivers: present queue heads on the falling edge, retire on acceptance.
  initial begin
    s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;
    forever begin
      @(negedge clk);
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (hold0 > 0) begin hold0--; s0_valid = 1'b0; end
      else if (q0.size() > 0) begin s0_valid = 1'b1; {s0_sop, s0_eop, s0_data} = q0[0]; end
      else s0_valid = 1'b0;
      if (hold1 > 0) begin hold1--; s1_valid = 1'b0; end
      else if (q1.size() > 0) begin s1_valid = 1'b1; {s1_sop, s1_eop, s1_data} = q1[0]; end
      else s1_valid = 1'b0;
      acc0 = s0_valid && s0_ready;
      acc1 = s1_valid && s1_ready;
      if (acc0 && s0_sop) sop_cyc0 = cyc;
      if (acc1 && s1_sop) sop_cyc1 = cyc;
    end
  end

  // Sink monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && src_ready) out_q.push_back({m_sop, m_eop, m_d0, m_d1});
      if (m_err) err_cnt++;
    end
  end

  initial begin
    rst = 1'b1;
    src_ready = 1'b1;
    hold0 = 0; hold1 = 0; first_v = -1; err_cnt = 0;
    sop_cyc0 = 0; sop_cyc1 = 0;
    @(posedge clk);
    #1;

    // Lockstep 4-beat frame.
    do_reset();
    push_beats(0, 1, 4, 0, 3);
    push_beats(1, 1, 4, 0, 3);
    expect_pairs(1, 4, 3);
    run(20);
    compare_out("t1");
    chk("t1_latency", 80'(first_v), 80'(sop_cyc0 + 2));
    chk("t1_frame", 80'(frame_cnt), 80'(1));
    chk("t1_drop", 80'(drop_cnt), 80'(0));
    chk("t1_err", 80'(err_cnt), 80'(0));

    // Channel 0 leads with a 3-beat tail.
    do_reset();
    push_beats(0, 9, 3, -1, 2);
    push_beats(0, 2, 4, 0, 3);
    push_beats(1, 2, 4, 0, 3);
    expect_pairs(2, 4, 3);
    run(25);
    compare_out("t2");
    chk("t2_drop", 80'(drop_cnt), 80'(3));
    chk("t2_frame", 80'(frame_cnt), 80'(1));
    chk("t2_err", 80'(err_cnt), 80'(0));

    // Channel 1 eop one beat early, then a clean frame.
    do_reset();
    push_beats(0, 3, 4, 0, 3);
    push_beats(1, 3, 3, 0, 2);
    push_beats(0, 4, 4, 0, 3);
    push_beats(1, 4, 4, 0, 3);
    exp_q.push_back({1'b1, 1'b0, px(0, 3, 0), px(1, 3, 0)});
    exp_q.push_back({1'b0, 1'b0, px(0, 3, 1), px(1, 3, 1)});
    expect_pairs(4, 4, 3);
    run(30);
    compare_out("t3");
    chk("t3_err", 80'(err_cnt), 80'(1));
    chk("t3_drop", 80'(drop_cnt), 80'(3));
    chk("t3_frame", 80'(frame_cnt), 80'(1));

    // Downstream stalled for 40 cycles with 24-beat frames.
    do_reset();
    src_ready = 1'b0;
    push_beats(0, 5, 24, 0, 23);
    push_beats(1, 5, 24, 0, 23);
    expect_pairs(5, 24, 23);
    run(40);
    chk("t4_ready0_full", 80'(s0_ready), 80'(0));
    chk("t4_ready1_full", 80'(s1_ready), 80'(0));
    chk("t4_pending0", 80'(q0.size()), 80'(8));
    chk("t4_pending1", 80'(q1.size()), 80'(8));
    chk("t4_held", 80'(out_q.size()), 80'(0));
    src_ready = 1'b1;
    run(50);
    compare_out("t4");
    chk("t4_frame", 80'(frame_cnt), 80'(1));
    chk("t4_drop", 80'(drop_cnt), 80'(0));

    // Channel 1 starts 7 cycles late.
    do_reset();
    hold1 = 7;
    push_beats(0, 6, 6, 0, 5);
    push_beats(1, 6, 6, 0, 5);
    expect_pairs(6, 6, 5);
    run(30);
    compare_out("t5");
    chk("t5_skew", 80'(sop_cyc1 - sop_cyc0), 80'(7));
    chk("t5_latency", 80'(first_v), 80'(sop_cyc1 + 2));
    chk("t5_frame", 80'(frame_cnt), 80'(1));

    // Reset mid-frame, then a clean frame.
    do_reset();
    push_beats(0, 7, 8, 0, 7);
    push_beats(1, 7, 8, 0, 7);
    run(6);
    chk("t6_partial", 80'(out_q.size()), 80'(4));
    do_reset();
    push_beats(0, 8, 4, 0, 3);
    push_beats(1, 8, 4, 0, 3);
    expect_pairs(8, 4, 3);
    run(20);
    compare_out("t6");
    chk("t6_frame", 80'(frame_cnt), 80'(1));
    chk("t6_drop", 80'(drop_cnt), 80'(0));
    chk("t6_err", 80'(err_cnt), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
